io_intr_hub: RTL and testbench

- Parametrised successor to the single-byte `r_data`/`irr`/`w_busy` I/O path of the CPU.
- Gives NCH receive channels, each with its own DEPTH-entry FIFO, and per-channel interrupt masking.
- Arbitrates pending channels by fixed priority and presents one byte plus its channel index to the decode stage.
- Also carries a single shared transmit port with a `w_req`/`w_busy` handshake toward a downstream ready/valid sink.

---
 rtl/lib_io_pkg.sv | 31 +++
 rtl/io_fifo.sv | 55 +++++
 rtl/io_intr_hub.sv | 126 ++++++++++++
 tb/tb_io_intr_hub.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lib_io_pkg.sv
// Shared I/O types for the interrupt hub: transmit request, receive view and
// transmit-slot state, plus the channel-index width helper.
package lib_io;

    localparam int IO_NCH = 2;
    localparam int IO_DW  = 8;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IO_CW = ch_width(IO_NCH);

    typedef struct packed {
        logic             w_req;
        logic [IO_CW-1:0] w_ch;
        logic [IO_DW-1:0] w_data;
    } io_tx_req_t;

    typedef struct packed {
        logic             irr;
        logic [IO_CW-1:0] intr_ch;
        logic [IO_DW-1:0] r_data;
    } io_rx_view_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_t;

endpackage

// File: rtl/io_fifo.sv
// Per-channel receive FIFO with a combinational head. A push into a full FIFO
// is accepted only if a pop frees the slot in the same cycle.
module io_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   cnt_reg;
    logic [DW-1:0] mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full     = (cnt_reg == (AW+1)'(DEPTH));
    assign empty    = (cnt_reg == '0);
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign overflow = push & full & ~pop_ok;
    assign dout     = mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by cnt_reg.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/io_intr_hub.sv
// Multi-channel receive hub with fixed-priority interrupt arbitration and a
// single-slot transmit port toward a ready/valid sink.
module io_intr_hub
    import lib_io::*;
#(
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = ch_width(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              intr_en,
    input  logic [NCH-1:0]    intr_mask,
    input  logic [NCH-1:0]    rx_valid,
    input  logic [NCH*DW-1:0] rx_data,
    input  logic              ack,
    output logic              irr,
    output logic [CW-1:0]     intr_ch,
    output logic [DW-1:0]     r_data,
    output logic [NCH-1:0]    ovf,
    input  logic [NCH-1:0]    ovf_clr,
    input  logic              w_req,
    input  logic [CW-1:0]     w_ch,
    input  logic [DW-1:0]     w_data,
    output logic              w_busy,
    output logic              w_drop,
    output logic              tx_valid,
    output logic [CW-1:0]     tx_ch,
    output logic [DW-1:0]     tx_data,
    input  logic              tx_ready
);

    logic [NCH-1:0] empty;
    logic [NCH-1:0] full_unused;
    logic [NCH-1:0] pop;
    logic [NCH-1:0] ovf_set;
    logic [NCH-1:0] pend;
    logic [DW-1:0]  head [NCH];
    logic [NCH-1:0] ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .push     (rx_valid[gi]),
                .pop      (pop[gi]),
                .din      (rx_data[gi*DW +: DW]),
                .dout     (head[gi]),
                .full     (full_unused[gi]),
                .empty    (empty[gi]),
                .overflow (ovf_set[gi])
            );
            assign pop[gi]  = ack & irr & (intr_ch == CW'(gi));
            assign pend[gi] = ~empty[gi] & intr_mask[gi];
        end
    endgenerate

    // Lowest pending index wins; scan from the top so the last hit is lowest.
    always_comb begin
        intr_ch = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pend[k]) intr_ch = CW'(k);
        end
    end

    assign irr    = intr_en & (|pend);
    assign r_data = irr ? head[intr_ch] : '0;
    assign ovf    = ovf_reg;

    // Set takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_reg <= '0;
        else     ovf_reg <= (ovf_reg & ~ovf_clr) | ovf_set;
    end

    tx_state_t     state_reg, state_next;
    logic [CW-1:0] tx_ch_reg;
    logic [DW-1:0] tx_data_reg;
    logic          w_drop_reg, w_drop_next;
    logic          tx_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= TX_IDLE;
            tx_ch_reg   <= '0;
            tx_data_reg <= '0;
            w_drop_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            w_drop_reg <= w_drop_next;
            if (tx_load) begin
                tx_ch_reg   <= w_ch;
                tx_data_reg <= w_data;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        tx_load     = 1'b0;
        w_drop_next = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                if (w_req) begin
                    tx_load    = 1'b1;
                    state_next = TX_HOLD;
                end
            end
            TX_HOLD: begin
                if (tx_ready) state_next  = TX_IDLE;
                if (w_req)    w_drop_next = 1'b1;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    assign tx_valid = (state_reg == TX_HOLD);
    assign w_busy   = tx_valid;
    assign tx_ch    = tx_ch_reg;
    assign tx_data  = tx_data_reg;
    assign w_drop   = w_drop_reg;

endmodule

// File: tb/tb_io_intr_hub.sv
// Directed bench for io_intr_hub (NCH=2, DW=8, DEPTH=4): receive arbitration,
// overflow, full-boundary push/pop, masking and the transmit handshake.
module tb_io_intr_hub;

    logic        clk = 1'b0;
    logic        rst;
    logic        intr_en;
    logic [1:0]  intr_mask;
    logic [1:0]  rx_valid;
    logic [15:0] rx_data;
    logic        ack;
    logic        irr;
    logic        intr_ch;
    logic [7:0]  r_data;
    logic [1:0]  ovf;
    logic [1:0]  ovf_clr;
    logic        w_req;
    logic        w_ch;
    logic [7:0]  w_data;
    logic        w_busy;
    logic        w_drop;
    logic        tx_valid;
    logic        tx_ch;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_intr_hub #(.NCH(2), .DW(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .intr_en(intr_en), .intr_mask(intr_mask),
        .rx_valid(rx_valid), .rx_data(rx_data), .ack(ack), .irr(irr),
        .intr_ch(intr_ch), .r_data(r_data), .ovf(ovf), .ovf_clr(ovf_clr),
        .w_req(w_req), .w_ch(w_ch), .w_data(w_data), .w_busy(w_busy),
        .w_drop(w_drop), .tx_valid(tx_valid), .tx_ch(tx_ch), .tx_data(tx_data),
        .tx_ready(tx_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        rx_valid = 2'b00;
        rx_valid[ch] = 1'b1;
        rx_data = '0;
        rx_data[ch*8 +: 8] = b;
        step();
        rx_valid = 2'b00;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; intr_en = 1'b0; intr_mask = 2'b00; rx_valid = 2'b00;
        rx_data = '0; ack = 1'b0; ovf_clr = 2'b00; w_req = 1'b0; w_ch = 1'b0;
        w_data = '0; tx_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_irr", irr, 0);
        chk("rst_intr_ch", intr_ch, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_w_busy", w_busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_ch", tx_ch, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_w_drop", w_drop, 0);

        // Single byte on ch1, then ack
        intr_en = 1'b1; intr_mask = 2'b11;
        push(1, 8'h41);
        chk("t1_irr", irr, 1);
        chk("t1_intr_ch", intr_ch, 1);
        chk("t1_r_data", r_data, 8'h41);
        do_ack();
        chk("t1_irr_after", irr, 0);

        // Priority: ch0 wins over an earlier ch1 byte
        push(1, 8'h11);
        push(0, 8'h22);
        chk("pri_ch", intr_ch, 0);
        chk("pri_data", r_data, 8'h22);
        do_ack();
        chk("pri_ch2", intr_ch, 1);
        chk("pri_data2", r_data, 8'h11);
        do_ack();
        chk("pri_irr_end", irr, 0);

        // Overflow: fifth push into a full FIFO is dropped
        for (int i = 1; i <= 4; i++) push(0, 8'(i));
        chk("ovf_at_full", ovf, 2'b00);
        push(0, 8'h05);
        chk("ovf_set", ovf, 2'b01);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_rd_irr", irr, 1);
            chk("ovf_rd_data", r_data, i);
            do_ack();
        end
        chk("ovf_empty", irr, 0);
        chk("ovf_sticky", ovf, 2'b01);
        ovf_clr = 2'b01;
        step();
        ovf_clr = 2'b00;
        chk("ovf_clr", ovf, 2'b00);

        // Full boundary: push and pop together at full is not an overflow
        for (int i = 1; i <= 4; i++) push(0, 8'h90 + 8'(i));
        ack = 1'b1;
        push(0, 8'h99);
        ack = 1'b0;
        chk("fb_no_ovf", ovf, 2'b00);
        chk("fb_head", r_data, 8'h92);
        push(0, 8'hEE);
        chk("fb_still_full", ovf, 2'b01);
        ovf_clr = 2'b01;
        step();
        ovf_clr = 2'b00;
        chk("fb_head_b", r_data, 8'h92); do_ack();
        chk("fb_head_c", r_data, 8'h93); do_ack();
        chk("fb_head_d", r_data, 8'h94); do_ack();
        chk("fb_head_e", r_data, 8'h99); do_ack();
        chk("fb_empty", irr, 0);

        // Masking and global enable
        intr_mask = 2'b10;
        push(0, 8'h77);
        chk("mask_irr0", irr, 0);
        chk("mask_rdata0", r_data, 0);
        intr_mask = 2'b11;
        #1;
        chk("mask_irr1", irr, 1);
        chk("mask_ch", intr_ch, 0);
        intr_en = 1'b0;
        #1;
        chk("en_off_irr", irr, 0);
        do_ack();
        intr_en = 1'b1;
        #1;
        chk("en_on_irr", irr, 1);
        chk("en_on_data", r_data, 8'h77);
        do_ack();
        chk("en_drained", irr, 0);

        // Transmit handshake
        w_req = 1'b1; w_ch = 1'b1; w_data = 8'h5A;
        step();
        w_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("tx_busy", w_busy, 1);
            chk("tx_valid", tx_valid, 1);
            chk("tx_ch", tx_ch, 1);
            chk("tx_data", tx_data, 8'h5A);
            if (i < 2) step();
        end
        w_req = 1'b1; w_ch = 1'b0; w_data = 8'hA5;
        step();
        w_req = 1'b0;
        chk("tx_drop", w_drop, 1);
        chk("tx_hold_data", tx_data, 8'h5A);
        chk("tx_hold_ch", tx_ch, 1);
        step();
        chk("tx_drop_end", w_drop, 0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("tx_done_busy", w_busy, 0);
        chk("tx_done_valid", tx_valid, 0);

        // Reset while holding discards the byte and FIFO contents
        w_req = 1'b1; w_ch = 1'b1; w_data = 8'h3C;
        rx_valid = 2'b01; rx_data = 16'h0055;
        step();
        w_req = 1'b0; rx_valid = 2'b00;
        chk("tx2_busy", w_busy, 1);
        chk("tx2_data", tx_data, 8'h3C);
        chk("pre_rst_irr", irr, 1);
        rst = 1'b1;
        #1;
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_w_busy", w_busy, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_irr", irr, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_irr", irr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
